fp_result_queue: RTL and testbench
==================================

Name: fp_result_queue

Overview:
Downstream stage of the serial 32-bit FP adder (fpadder). Captures each completed sum when the adder asserts ready, classifies it per IEEE-754 single precision, and buffers it in a small FIFO. Results are presented to the consumer through a valid/accept handshake, so consumer stalls do not lose adder results until the queue overflows.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2.
CNT_W, 8, width of the saturating drop counter.

Ports:
clock  input  1  system clock, rising-edge active.
reset  input  1  synchronous, active-high reset.
sum  input  32  adder result; sampled only on a capture cycle.
sum_ready  input  1  adder ready level; a 0->1 transition marks a new result.
clear_ovf  input  1  one-cycle pulse; clears overflow and drop_cnt.
out_data  output  32  head-of-queue result.
out_class  output  3  head class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
out_sign  output  1  head sign bit, equal to out_data[31].
out_valid  output  1  queue non-empty.
out_accept  input  1  consumer takes the head when out_valid && out_accept.
count  output  $clog2(DEPTH)+1  current occupancy.
full  output  1  count == DEPTH.
overflow  output  1  sticky; set when a result is dropped.
drop_cnt  output  CNT_W  number of dropped results, saturating.

Behaviour:
- Interface: single clock domain, clock; reset is synchronous and active-high. Sampled on a clock rising edge with reset=1, it overrides all other inputs.
- Reset values: out_data=0, out_class=0, out_sign=0, out_valid=0, count=0, full=0, overflow=0, drop_cnt=0, rd_ptr=wr_ptr=0, rdy_q=1.
- Edge detect:
  - rdy_q is a register of sum_ready; capture = sum_ready && !rdy_q.
  - rdy_q resets to 1, so a sum_ready already high at reset release does not capture.
  - Exactly one capture per rising edge; a held-high sum_ready does not re-capture.
- Classification is combinational on sum at capture and stored with the entry (e = sum[30:23], f = sum[22:0]):
  - e=0, f=0 -> zero.
  - e=0, f!=0 -> subnormal.
  - e=0xFF, f=0 -> inf.
  - e=0xFF, f[22]=1 -> qNaN.
  - e=0xFF, f[22]=0, f!=0 -> sNaN.
  - otherwise -> normal.
- Push/pop:
  - push = capture && (!full || pop).
  - pop = out_valid && out_accept.
  - Both use registered state; count updates by +1, -1 or 0.
  - When full with pop and capture in the same cycle, the push is accepted and count stays DEPTH.
- Pointers: rd_ptr and wr_ptr wrap modulo DEPTH.
- Output timing:
  - Outputs are driven from the head entry, show-ahead.
  - A result written into an empty queue appears on out_* the cycle after capture (latency 1 from the sum_ready rising edge).
  - When empty, out_data, out_class and out_sign read 0.
- Overflow:
  - capture && full && !pop -> result dropped, FIFO contents unchanged, overflow<=1, drop_cnt increments and saturates at 2^CNT_W-1.
  - If clear_ovf and a drop occur in the same cycle, the clear wins for overflow (cleared to 0), and drop_cnt is loaded with 1.
- out_accept while !out_valid is ignored.
- Reset during operation: the queue empties the next cycle, all entries are discarded, and rdy_q=1.

Test Plan:
1. Reset with sum_ready held at 1, then release -> no capture, out_valid=0, count=0. Drop sum_ready to 0, then raise it with sum=0x423490fd -> the next cycle out_valid=1, out_data=0x423490fd, out_class=2, out_sign=0.
2. Classification with out_accept=1: push 0x80000000, 0x00400000, 0x7f800000, 0x7fc00000, 0x7fa00000, 0xedfe85a6 -> out_class 0 (sign 1), 1, 3, 4, 5, 2 (sign 1), in order.
3. out_accept=0, push 5 results with DEPTH=4 -> full=1 after the 4th, the 5th is dropped: overflow=1, drop_cnt=1, and the head is still the first result. Then pulse clear_ovf -> overflow=0, drop_cnt=0.
4. Queue full, out_accept=1 in the same cycle as a capture of 0x3f800000 -> the head pops, the new entry is accepted, count stays 4, overflow stays 0. Drain -> values come out in FIFO order, wrap-around is correct, and count reaches 0.
5. Hold sum_ready high for 10 cycles -> exactly one entry is captured.
6. Assert reset with count=3 -> the next cycle count=0, out_valid=0, out_data=0, overflow=0.

Source files
------------

// File: rtl/fp_result_queue.sv
// Result queue behind the serial FP adder: edge-detects sum_ready, classifies each sum,
// and buffers it in a show-ahead FIFO with a sticky overflow flag and saturating drop counter.
module fp_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              sum,
  input  logic                     sum_ready,
  input  logic                     clear_ovf,
  output logic [31:0]              out_data,
  output logic [2:0]               out_class,
  output logic                     out_sign,
  output logic                     out_valid,
  input  logic                     out_accept,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    ClsZero   = 3'd0,
    ClsSubnrm = 3'd1,
    ClsNormal = 3'd2,
    ClsInf    = 3'd3,
    ClsQnan   = 3'd4,
    ClsSnan   = 3'd5
  } fp_class_e;

  logic [31:0]      data_mem [DEPTH];
  logic [2:0]       cls_mem  [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             rdy_q;
  logic             overflow_q;
  logic [CNT_W-1:0] drop_q;

  logic             capture, push, pop, drop;
  fp_class_e        sum_class;
  logic [7:0]       sum_exp;
  logic [22:0]      sum_frac;

  assign sum_exp  = sum[30:23];
  assign sum_frac = sum[22:0];

  always_comb begin
    sum_class = ClsNormal;
    if (sum_exp == 8'h00) begin
      sum_class = (sum_frac == 23'd0) ? ClsZero : ClsSubnrm;
    end else if (sum_exp == 8'hFF) begin
      if (sum_frac == 23'd0)  sum_class = ClsInf;
      else if (sum_frac[22])  sum_class = ClsQnan;
      else                    sum_class = ClsSnan;
    end
  end

  // rdy_q resets high so a level already asserted at reset release is not a new result.
  assign capture   = sum_ready & ~rdy_q;
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = out_valid & out_accept;
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_q      <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rdy_q <= sum_ready;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A clear coinciding with a drop clears the flag but still counts that drop.
      if (clear_ovf) begin
        overflow_q <= 1'b0;
        drop_q     <= drop ? CNT_W'(1) : '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= sum;
      cls_mem[wr_ptr_q]  <= sum_class;
    end
  end

  assign out_data  = out_valid ? data_mem[rd_ptr_q] : 32'd0;
  assign out_class = out_valid ? cls_mem[rd_ptr_q] : 3'd0;
  assign out_sign  = out_data[31];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fp_result_queue.sv
// Self-checking bench for fp_result_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fp_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] sum;
  logic        sum_ready;
  logic        clear_ovf;
  logic [31:0] out_data;
  logic [2:0]  out_class;
  logic        out_sign;
  logic        out_valid;
  logic        out_accept;
  logic [$clog2(DEPTH):0] count;
  logic        full;
  logic        overflow;
  logic [CNT_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        m_ovf;
  int          m_drop;
  logic        m_prev;

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .sum(sum), .sum_ready(sum_ready), .clear_ovf(clear_ovf),
    .out_data(out_data), .out_class(out_class), .out_sign(out_sign), .out_valid(out_valid),
    .out_accept(out_accept), .count(count), .full(full), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  function automatic int ref_class(input logic [31:0] v);
    int e, f;
    e = int'((v >> 23) & 32'hFF);
    f = int'(v & 32'h7FFFFF);
    if (e == 0)   return (f == 0) ? 0 : 1;
    if (e == 255) begin
      if (f == 0)          return 3;
      if (f >= 'h400000)   return 4;
      return 5;
    end
    return 2;
  endfunction

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    bit cap, pop, drop;
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_drop = 0; m_prev = 1;
    end else begin
      cap  = sum_ready && !m_prev;
      pop  = (mq.size() > 0) && out_accept;
      drop = cap && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (cap && !drop) mq.push_back(sum);
      if (clear_ovf) begin
        m_ovf = 0;
        m_drop = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_drop < DROP_MAX) m_drop++;
      end
      m_prev = sum_ready;
    end
    #1;
  endtask

  task automatic push_result(input logic [31:0] v);
    sum = v; sum_ready = 1'b0; tick();
    sum_ready = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sum_ready = 1'b1; sum = 32'h1234_5678;
    tick(); tick();
    reset = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_data !== 32'd0) begin errors++;
      $display("FAIL reset_data got=%h exp=0", out_data); end
    push_result(32'h4234_90fd);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h4234_90fd) begin errors++;
      $display("FAIL first_capture got=%b/%h exp=1/423490fd", out_valid, out_data); end
    checks++; if (out_class !== 3'd2 || out_sign !== 1'b0) begin errors++;
      $display("FAIL first_class got=%0d/%b exp=2/0", out_class, out_sign); end
  endtask

  task automatic test_classify();
    logic [31:0] vals [6] = '{32'h8000_0000, 32'h0040_0000, 32'h7f80_0000,
                              32'h7fc0_0000, 32'h7fa0_0000, 32'hedfe_85a6};
    int          cls  [6] = '{0, 1, 3, 4, 5, 2};
    logic        sgn  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_accept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_result(vals[i]);
      checks++; if (out_data !== vals[i] || out_class !== cls[i][2:0] || out_sign !== sgn[i])
      begin errors++;
        $display("FAIL classify[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, out_data, out_class,
                 out_sign, vals[i], cls[i], sgn[i]);
      end
    end
    sum_ready = 1'b0; tick();
    out_accept = 1'b0;
    checks++; if (count !== 0) begin errors++; $display("FAIL classify_drain got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [5] = '{32'h3f80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                              32'h40a0_0000};
    for (int i = 0; i < 5; i++) begin
      push_result(vals[i]);
      if (i == 3) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++;
          $display("FAIL full_at_4 got=%b/%b exp=1/0", full, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++;
      $display("FAIL drop_5th got=%b/%0d exp=1/1", overflow, drop_cnt); end
    checks++; if (out_data !== vals[0] || count !== 4) begin errors++;
      $display("FAIL head_kept got=%h/%0d exp=%h/4", out_data, count, vals[0]); end
    sum_ready = 1'b0; clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++;
      $display("FAIL clear_ovf got=%b/%0d exp=0/0", overflow, drop_cnt); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] exp_order [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3f80_0000};
    sum = 32'h3f80_0000; sum_ready = 1'b0; tick();
    sum_ready = 1'b1; out_accept = 1'b1; tick();
    sum_ready = 1'b0;
    checks++; if (count !== 4 || overflow !== 1'b0 || out_data !== exp_order[0]) begin errors++;
      $display("FAIL full_pop_push got=%0d/%b/%h exp=4/0/%h", count, overflow, out_data,
               exp_order[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_order[i]) begin errors++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, out_data, exp_order[i]); end
      tick();
    end
    out_accept = 1'b0;
    checks++; if (count !== 0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_held_ready();
    sum = 32'hc000_0000; sum_ready = 1'b0; tick();
    sum_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (count !== 1 || out_data !== 32'hc000_0000) begin errors++;
      $display("FAIL held_ready got=%0d/%h exp=1/c0000000", count, out_data); end
  endtask

  task automatic test_reset_midway();
    push_result(32'h4120_0000);
    push_result(32'h4130_0000);
    sum_ready = 1'b0;
    checks++; if (count !== 3) begin errors++; $display("FAIL pre_reset got=%0d exp=3", count); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (count !== 0 || out_valid !== 1'b0 || out_data !== 32'd0 || overflow !== 1'b0)
    begin errors++;
      $display("FAIL mid_reset got=%0d/%b/%h/%b exp=0/0/0/0", count, out_valid, out_data,
               overflow);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DEPTH; i++) push_result(32'h3f00_0000 + i);
    for (int i = 0; i < DROP_MAX + 5; i++) push_result(32'h4f00_0000);
    checks++; if (drop_cnt !== DROP_MAX[CNT_W-1:0] || overflow !== 1'b1) begin errors++;
      $display("FAIL saturate got=%0d/%b exp=%0d/1", drop_cnt, overflow, DROP_MAX); end
    sum_ready = 1'b0; tick();
    sum_ready = 1'b1; clear_ovf = 1'b1; tick(); clear_ovf = 1'b0; sum_ready = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd1) begin errors++;
      $display("FAIL clear_and_drop got=%b/%0d exp=0/1", overflow, drop_cnt); end
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] specials [6] = '{32'h0, 32'h8000_0001, 32'h7f80_0000, 32'hffc0_0001,
                                  32'h7f80_0001, 32'h0080_0000};
    logic [31:0] e_data;
    for (int n = 0; n < 600; n++) begin
      sum        = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
      sum_ready  = 1'($urandom_range(1));
      out_accept = ($urandom_range(3) == 0);
      clear_ovf  = ($urandom_range(15) == 0);
      reset      = ($urandom_range(99) == 0);
      tick();
      e_data = (mq.size() > 0) ? mq[0] : 32'd0;
      checks++;
      if (out_data !== e_data || out_valid !== (mq.size() > 0) || count !== mq.size() ||
          full !== (mq.size() == DEPTH) || out_class !== 3'(ref_class(e_data)) ||
          out_sign !== e_data[31] || overflow !== m_ovf || drop_cnt !== CNT_W'(m_drop)) begin
        errors++;
        $display("FAIL random[%0d] got=%h c%0d s%b v%b n%0d f%b o%b d%0d exp=%h c%0d n%0d o%b d%0d",
                 n, out_data, out_class, out_sign, out_valid, count, full, overflow, drop_cnt,
                 e_data, ref_class(e_data), mq.size(), m_ovf, m_drop);
      end
    end
    reset = 1'b0; clear_ovf = 1'b0; out_accept = 1'b0; sum_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sum = '0; sum_ready = 1'b0; clear_ovf = 1'b0; out_accept = 1'b0;
    m_ovf = 0; m_drop = 0; m_prev = 1;
    test_reset();
    test_classify();
    test_overflow();
    test_full_pop_push();
    test_held_ready();
    test_reset_midway();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
